// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data-memory RAM (port 0 = core LSU, port 1 = loader/DMA); ARB_RR_EN selects round-robin.
// Latency: grant is combinational in the request cycle; read data / error response returns exactly one cycle after grant.
// Backpressure: a losing requester holds its request until granted; port 1 is forced through after STARVE_LIMIT consecutive losses.
module data_mem_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  typedef enum logic {FREE, LOCK1} lock_state_t;

  lock_state_t lock_state;
  logic [7:0]  starve_cnt;
  logic        last_winner;   // 0 = port 0 won last, 1 = port 1 won last
  logic        m0_tag_vld, m0_tag_err;
  logic        m1_tag_vld, m1_tag_err;

  logic        m0_oor, m1_oor;
  logic        sel_oor, sel_we;
  logic [31:0] sel_addr, sel_wdata;

  assign m0_oor = |(m0_addr >> ADDR_W);
  assign m1_oor = |(m1_addr >> ADDR_W);

  // Grant decision: lock ownership first, then starvation override, then priority / round-robin.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (lock_state == LOCK1) begin
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        if (starve_cnt >= STARVE_LIM)    m1_gnt = 1'b1;
        else if (RR_EN && !last_winner)  m1_gnt = 1'b1;
        else                             m0_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // RAM side: route the granted request; out-of-range accesses never touch the RAM.
  always_comb begin
    sel_oor   = m1_gnt ? m1_oor   : m0_oor;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    mem_en    = (m0_gnt || m1_gnt) && !sel_oor;
    mem_we    = mem_en && sel_we;
    mem_addr  = mem_en ? sel_addr[ADDR_W-1:0] : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
  end

  // Lock FSM, starvation counter, last winner and per-port response tags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      lock_state  <= FREE;
      starve_cnt  <= 8'd0;
      last_winner <= 1'b1;
      m0_tag_vld  <= 1'b0;
      m0_tag_err  <= 1'b0;
      m1_tag_vld  <= 1'b0;
      m1_tag_err  <= 1'b0;
    end else begin
      case (lock_state)
        FREE:    if (m1_gnt && m1_lock)  lock_state <= LOCK1;
        LOCK1:   if (!m1_lock || !m1_req) lock_state <= FREE;
        default: lock_state <= FREE;
      endcase

      // Counter is frozen while port 1 owns the RAM.
      if (lock_state == FREE) begin
        if (m1_gnt || !m1_req)          starve_cnt <= 8'd0;
        else if (starve_cnt != 8'hFF)   starve_cnt <= starve_cnt + 8'd1;
      end

      if (m0_gnt)      last_winner <= 1'b0;
      else if (m1_gnt) last_winner <= 1'b1;

      // A response is owed for reads and for any out-of-range access.
      m0_tag_vld <= m0_gnt && (m0_oor || !m0_we);
      m0_tag_err <= m0_gnt && m0_oor;
      m1_tag_vld <= m1_gnt && (m1_oor || !m1_we);
      m1_tag_err <= m1_gnt && m1_oor;
    end
  end

  // Responses are suppressed while reset is held so an in-flight access is dropped.
  always_comb begin
    m0_rvalid = m0_tag_vld && !reset;
    m0_err    = m0_rvalid && m0_tag_err;
    m0_rdata  = (m0_rvalid && !m0_tag_err) ? mem_rdata : 32'h0;
    m1_rvalid = m1_tag_vld && !reset;
    m1_err    = m1_rvalid && m1_tag_err;
    m1_rdata  = (m1_rvalid && !m1_tag_err) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand sequences, then random traffic vs a reference model.
// Latency: checks each cycle at the falling edge; responses expected one cycle after grant.
// Backpressure: random requesters hold their request until granted.
module tb_data_mem_arbiter;
  localparam int ADDR_W       = 17;
  localparam int STARVE_LIMIT = 8;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              rq [2];
  logic              rw [2];
  logic [31:0]       ra [2];
  logic [31:0]       rwd [2];
  logic              lk1;
  logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       ram [0:1023];
  logic [31:0]       ram_q = 32'h0;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(clk), .reset(rst),
    .m0_req(rq[0]), .m0_we(rw[0]), .m0_addr(ra[0]), .m0_wdata(rwd[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(rq[1]), .m1_we(rw[1]), .m1_addr(ra[1]), .m1_wdata(rwd[1]), .m1_lock(lk1),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(ram_q)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        ram_q <= ram[mem_addr[9:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    rq[p] = r; rw[p] = we; ra[p] = a; rwd[p] = d;
  endtask

  task automatic set_idle();
    set_req(0, L, L, 32'h0, 32'h0);
    set_req(1, L, L, 32'h0, 32'h0);
    lk1 = L;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = H;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = L;
  endtask

  typedef struct {
    logic        rst;
    logic        r0, we0; logic [31:0] a0, d0;
    logic        r1, we1, lk1; logic [31:0] a1, d1;
    logic        g0, g1, rv0, er0; logic [31:0] rd0;
    logic        rv1, er1; logic [31:0] rd1;
    logic        men, mwe; logic [31:0] ma;
  } vec_t;

  vec_t tbl [10];

  // Reference model state
  bit          m_lock;
  int          m_loss;
  int          m_last;
  bit          pv [2];
  bit          pe [2];
  logic [31:0] pd [2];
  int          win;
  logic [31:0] shadow [int];

  initial begin
    rst = H;
    set_idle();
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[16] = 32'hDEADBEEF;

    tbl[0] = '{H, H,L,32'h10,32'h0,          L,L,L,32'h0,32'h0,               L,L,L,L,32'h0,          L,L,32'h0,       L,L,32'h0};
    tbl[1] = '{L, H,L,32'h10,32'h0,          L,L,L,32'h0,32'h0,               H,L,L,L,32'h0,          L,L,32'h0,       H,L,32'h10};
    tbl[2] = '{L, L,L,32'h0,32'h0,           L,L,L,32'h0,32'h0,               L,L,H,L,32'hDEADBEEF,   L,L,32'h0,       L,L,32'h0};
    tbl[3] = '{L, L,L,32'h0,32'h0,           H,H,L,32'h20,32'h12345678,       L,H,L,L,32'h0,          L,L,32'h0,       H,H,32'h20};
    tbl[4] = '{L, L,L,32'h0,32'h0,           H,L,L,32'h20,32'h0,              L,H,L,L,32'h0,          L,L,32'h0,       H,L,32'h20};
    tbl[5] = '{L, H,H,32'h20000,32'hA5A5A5A5, L,L,L,32'h0,32'h0,              H,L,L,L,32'h0,          H,L,32'h12345678, L,L,32'h0};
    tbl[6] = '{L, L,L,32'h0,32'h0,           L,L,L,32'h0,32'h0,               L,L,H,H,32'h0,          L,L,32'h0,       L,L,32'h0};
    tbl[7] = '{L, L,L,32'h0,32'h0,           H,L,L,32'h80000004,32'h0,        L,H,L,L,32'h0,          L,L,32'h0,       L,L,32'h0};
    tbl[8] = '{L, H,L,32'h20,32'h0,          L,L,L,32'h0,32'h0,               H,L,L,L,32'h0,          H,H,32'h0,       H,L,32'h20};
    tbl[9] = '{L, L,L,32'h0,32'h0,           L,L,L,32'h0,32'h0,               L,L,H,L,32'h12345678,   L,L,32'h0,       L,L,32'h0};

    repeat (2) @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst;
      set_req(0, tbl[i].r0, tbl[i].we0, tbl[i].a0, tbl[i].d0);
      set_req(1, tbl[i].r1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      lk1 = tbl[i].lk1;
      @(negedge clk);
      chk1($sformatf("vec%0d m0_gnt", i), m0_gnt, tbl[i].g0);
      chk1($sformatf("vec%0d m1_gnt", i), m1_gnt, tbl[i].g1);
      chk1($sformatf("vec%0d m0_rvalid", i), m0_rvalid, tbl[i].rv0);
      chk1($sformatf("vec%0d m0_err", i), m0_err, tbl[i].er0);
      chk32($sformatf("vec%0d m0_rdata", i), m0_rdata, tbl[i].rd0);
      chk1($sformatf("vec%0d m1_rvalid", i), m1_rvalid, tbl[i].rv1);
      chk1($sformatf("vec%0d m1_err", i), m1_err, tbl[i].er1);
      chk32($sformatf("vec%0d m1_rdata", i), m1_rdata, tbl[i].rd1);
      chk1($sformatf("vec%0d mem_en", i), mem_en, tbl[i].men);
      chk1($sformatf("vec%0d mem_we", i), mem_we, tbl[i].mwe);
      if (tbl[i].men) chk32($sformatf("vec%0d mem_addr", i), 32'(mem_addr), tbl[i].ma);
      next_cycle();
    end

    // Continuous contention: starvation override (fixed priority) or alternation (round-robin)
    do_reset();
    set_req(0, H, L, 32'h100, 32'h0);
    set_req(1, H, L, 32'h104, 32'h0);
    for (int i = 0; i < 27; i++) begin
      logic e1;
      e1 = RR ? (i % 2 == 1) : (i % 9 == 8);
      @(negedge clk);
      chk1($sformatf("contend%0d m1_gnt", i), m1_gnt, e1);
      chk1($sformatf("contend%0d m0_gnt", i), m0_gnt, !e1);
      next_cycle();
    end

    // Locked burst of four port 1 writes while port 0 waits
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(1, H, H, 32'h30 + 32'(k), 32'hC0DE0000 + 32'(k));
      lk1 = H;
      if (k == 1) set_req(0, H, L, 32'h10, 32'h0);
      @(negedge clk);
      chk1($sformatf("lock%0d m1_gnt", k), m1_gnt, H);
      chk1($sformatf("lock%0d m0_gnt", k), m0_gnt, L);
      next_cycle();
    end
    set_req(1, L, L, 32'h0, 32'h0);
    lk1 = L;
    @(negedge clk);
    chk1("unlock m0_gnt blocked", m0_gnt, L);
    next_cycle();
    @(negedge clk);
    chk1("unlock m0_gnt granted", m0_gnt, H);
    next_cycle();

    // Reset asserted the cycle after a port 1 read grant
    do_reset();
    set_req(1, H, L, 32'h10, 32'h0);
    @(negedge clk);
    chk1("rstdrop m1_gnt", m1_gnt, H);
    next_cycle();
    rst = H;
    set_idle();
    @(negedge clk);
    chk1("rstdrop m1_rvalid", m1_rvalid, L);
    chk32("rstdrop m1_rdata", m1_rdata, 32'h0);
    next_cycle();
    rst = L;
    @(negedge clk);
    chk32("postrst outputs",
          {26'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'h0);
    chk32("postrst rdata", m0_rdata | m1_rdata, 32'h0);
    chk1("postrst mem_en", mem_en, L);
    chk1("postrst mem_we", mem_we, L);
    next_cycle();

    // Random traffic against the reference model
    do_reset();
    m_lock = 0; m_loss = 0; m_last = 1; win = -1;
    pv[0] = 0; pv[1] = 0; pe[0] = 0; pe[1] = 0; pd[0] = 0; pd[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          oor;
      logic [31:0] a;
      logic        e_men;
      rst = ($urandom % 128) == 0;
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || win == p) begin
          rq[p]  = ($urandom % 4) != 0;
          rw[p]  = ($urandom % 2) == 1;
          ra[p]  = (($urandom % 8) == 0) ? (32'h100 | (32'h1 << (17 + $urandom % 15)))
                                        : (32'h100 + ($urandom % 16));
          rwd[p] = $urandom;
        end
      end
      lk1 = ($urandom % 3) == 0;

      win = -1;
      if (!rst) begin
        if (m_lock)                win = rq[1] ? 1 : -1;
        else if (rq[0] && rq[1])   win = (m_loss >= STARVE_LIMIT) ? 1 : (RR ? 1 - m_last : 0);
        else if (rq[0])            win = 0;
        else if (rq[1])            win = 1;
      end
      a     = (win >= 0) ? ra[win] : 32'h0;
      oor   = (a >> ADDR_W) != 0;
      e_men = (win >= 0) && !oor;

      @(negedge clk);
      chk1($sformatf("rnd%0d m0_gnt", cyc), m0_gnt, win == 0);
      chk1($sformatf("rnd%0d m1_gnt", cyc), m1_gnt, win == 1);
      chk1($sformatf("rnd%0d mem_en", cyc), mem_en, e_men);
      chk1($sformatf("rnd%0d mem_we", cyc), mem_we, e_men && rw[win]);
      if (e_men) chk32($sformatf("rnd%0d mem_addr", cyc), 32'(mem_addr), a & 32'h1FFFF);
      chk1($sformatf("rnd%0d m0_rvalid", cyc), m0_rvalid, !rst && pv[0]);
      chk1($sformatf("rnd%0d m0_err", cyc), m0_err, !rst && pv[0] && pe[0]);
      chk32($sformatf("rnd%0d m0_rdata", cyc), m0_rdata, (!rst && pv[0] && !pe[0]) ? pd[0] : 32'h0);
      chk1($sformatf("rnd%0d m1_rvalid", cyc), m1_rvalid, !rst && pv[1]);
      chk1($sformatf("rnd%0d m1_err", cyc), m1_err, !rst && pv[1] && pe[1]);
      chk32($sformatf("rnd%0d m1_rdata", cyc), m1_rdata, (!rst && pv[1] && !pe[1]) ? pd[1] : 32'h0);

      if (rst) begin
        m_lock = 0; m_loss = 0; m_last = 1;
        pv[0] = 0; pv[1] = 0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          pv[p] = (win == p) && (oor || !rw[p]);
          pe[p] = oor;
          pd[p] = 32'h0;
          if (win == p && !oor) begin
            if (rw[p]) shadow[int'(a)] = rwd[p];
            else       pd[p] = shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0;
          end
        end
        if (!m_lock) begin
          if (rq[1] && win != 1) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          else                   m_loss = 0;
        end
        m_lock = m_lock ? (rq[1] && lk1) : (win == 1 && lk1);
        if (win >= 0) m_last = win;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
